main_control_fsm: RTL
=====================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 opcode_in  input  7  instr[6:0] from the external instruction register; stable from DECODE until return to FETCH.
REQ-005 zero_in  input  1  ALU zero flag, same cycle.
REQ-006 PCWrite_out, IRWrite_out, RegWrite_out, MemWrite_out, AdrSrc_out, Branch_out, PCUpdate_out  output  1 each  datapath enables/selects.
REQ-007 ResultSrc_out, ALUSrcA_out, ALUSrcB_out, ALUOp_out  output  2 each  mux selects; ALUOp_out feeds the ALU control stage (00 add, 01 sub/compare, 10 decode func3/func7).
REQ-008 illegal_out  output  1  unsupported opcode seen in DECODE.
REQ-009 state_out  output  4  current state encoding, debug.
REQ-010 instr_count_out  output  32  retired-instruction counter.

Function
REQ-011 The block SHALL be a Moore FSM with a registered state; outputs are decoded combinationally from state, except PCWrite_out = (Branch_out & zero_in) | PCUpdate_out.
REQ-012 The states and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH.
REQ-013 The opcodes SHALL be: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-014 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU), BEQ (beq), JAL (jal), else FETCH; MEMADR->MEMREAD (lw) / MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-015 Per-state outputs SHALL be as follows; unlisted outputs are 0.
- FETCH: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-016 illegal_out SHALL be 1 only in DECODE with an unsupported opcode; it lasts one cycle, and no write enable is asserted for that instruction after FETCH.
REQ-017 Latency in cycles including FETCH SHALL be: lw 5; sw, R, I-ALU, jal 4; beq 3; illegal 2.
REQ-018 instr_count_out SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; it SHALL NOT increment on the illegal path.
REQ-019 instr_count_out SHALL wrap from FFFFFFFF to 00000000 without a flag.
REQ-020 A change of zero_in outside BEQ SHALL have no effect on any output.

Reset
REQ-021 On a clock edge with rst=1, state SHALL become FETCH and instr_count_out SHALL become 0, regardless of the current state.
REQ-022 While rst=1, PCWrite_out, IRWrite_out, RegWrite_out, MemWrite_out and illegal_out SHALL be forced to 0; other outputs follow the state.
REQ-023 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL abort the instruction with no further write enables and no count increment.

Structure
REQ-024 The package main_control_pkg SHALL hold the state enum, the opcode constants, and the ALUOp and mux-select encodings; it SHALL be shared with the ALU control stage and the datapath.
REQ-025 The block SHALL be a single module with no sub-module: a next-state process, an output decode, and the counter.

Verification
REQ-026 rst=1 for 2 cycles, then rst=0: state_out=0, count=0, and write enables stay 0 during reset; the first cycle after reset shows IRWrite=1 and PCWrite=1.
REQ-027 lw (0000011): states 0,1,2,3,4,0; RegWrite=1 only in state 4; count increments by 1 after 5 cycles.
REQ-028 beq with zero_in=1, then beq with zero_in=0: PCWrite=1 in BEQ only for the first; ALUOp=01 in BEQ for both; count=2.
REQ-029 R-type (0110011), then jal (1101111): ALUOp=10 in EXECUTER, then states 0,1,10,8,0 with PCUpdate=1 in JAL; both reach ALUWB with RegWrite=1.
REQ-030 Opcode 1111111: illegal_out=1 for one cycle in DECODE, return to FETCH, count unchanged.
REQ-031 Preload count to FFFFFFFF via a forced value and retire sw: count becomes 00000000. Separately, assert rst in MEMWRITE: MemWrite drops in the same cycle, then state 0.

Source files
------------

// File: rtl/main_control_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// ALUOp codes and datapath mux selects.
package main_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU operand A: PC, old PC (of the current instruction), register rs1
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Moore control FSM for a multicycle RV32 subset (lw/sw/R/I/beq/jal), with a
// retired-instruction counter.
module main_control_fsm
    import main_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_in,
    input  logic        zero_in,
    output logic        PCWrite_out,
    output logic        IRWrite_out,
    output logic        RegWrite_out,
    output logic        MemWrite_out,
    output logic        AdrSrc_out,
    output logic        Branch_out,
    output logic        PCUpdate_out,
    output logic [1:0]  ResultSrc_out,
    output logic [1:0]  ALUSrcA_out,
    output logic [1:0]  ALUSrcB_out,
    output logic [1:0]  ALUOp_out,
    output logic        illegal_out,
    output logic [3:0]  state_out,
    output logic [31:0] instr_count_out
);

    state_e      state_q, state_d;
    logic [31:0] instr_count_q;
    logic        retire;
    logic        legal_op;
    logic        irwrite, regwrite, memwrite;

    assign legal_op = (opcode_in == OP_LW) || (opcode_in == OP_SW) || (opcode_in == OP_R) ||
                      (opcode_in == OP_IALU) || (opcode_in == OP_BEQ) || (opcode_in == OP_JAL);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_in)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode_in == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Only the terminal states of a real instruction count; the illegal path
    // leaves DECODE straight to FETCH and is skipped.
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                    (state_q == S_ALUWB) || (state_q == S_BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) instr_count_q <= instr_count_q + 32'd1;
        end
    end

    always_comb begin
        irwrite       = 1'b0;
        regwrite      = 1'b0;
        memwrite      = 1'b0;
        AdrSrc_out    = 1'b0;
        Branch_out    = 1'b0;
        PCUpdate_out  = 1'b0;
        ResultSrc_out = RES_ALUOUT;
        ALUSrcA_out   = SRCA_PC;
        ALUSrcB_out   = SRCB_REG;
        ALUOp_out     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                irwrite       = 1'b1;
                PCUpdate_out  = 1'b1;
                ALUSrcB_out   = SRCB_FOUR;
                ResultSrc_out = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA_out = SRCA_OLDPC;
                ALUSrcB_out = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA_out = SRCA_REG;
                ALUSrcB_out = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc_out = 1'b1;
            S_MEMWB: begin
                ResultSrc_out = RES_DATA;
                regwrite      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc_out = 1'b1;
                memwrite   = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA_out = SRCA_REG;
                ALUOp_out   = ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                ALUSrcA_out = SRCA_REG;
                ALUSrcB_out = SRCB_IMM;
                ALUOp_out   = ALUOP_FUNC;
            end
            S_ALUWB:    regwrite = 1'b1;
            S_BEQ: begin
                ALUSrcA_out = SRCA_REG;
                ALUOp_out   = ALUOP_SUB;
                Branch_out  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA_out  = SRCA_OLDPC;
                ALUSrcB_out  = SRCB_FOUR;
                PCUpdate_out = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every write enable immediately so an aborted instruction
    // cannot commit in the cycle reset is raised.
    assign PCWrite_out     = !rst && ((Branch_out && zero_in) || PCUpdate_out);
    assign IRWrite_out     = !rst && irwrite;
    assign RegWrite_out    = !rst && regwrite;
    assign MemWrite_out    = !rst && memwrite;
    assign illegal_out     = !rst && (state_q == S_DECODE) && !legal_op;
    assign state_out       = state_q;
    assign instr_count_out = instr_count_q;

endmodule
